// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the data-memory responder slice.
// Contents:
//   state_t    - responder FSM states (idle / wait states / response)
//   WAIT_CNT_W - width of the wait-state counter (covers 0..15)
//   be_merge   - per-byte merge of store data into an existing RAM byte
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_CNT_W = 4;

    // Works on one byte lane so it stays independent of the data width;
    // callers loop it over every lane of a word.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old,
        input logic [7:0] wdata,
        input logic       be
    );
        return be ? wdata : old;
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Data RAM array: DEPTH_WORDS x DATA_WIDTH, combinational read,
// byte-enabled synchronous write, contents never reset.
// Ports:
//   i_clk    rising-edge clock for writes
//   i_we     write strobe for this cycle
//   i_addr   word index (shared by read and write)
//   i_wdata  write data
//   i_be     byte enables, one per byte lane of i_wdata
//   o_rdata  word currently addressed by i_addr
module dmem_ram_array
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_be,
    output logic [DATA_WIDTH-1:0]          o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Byte-lane write: lanes whose enable is low rewrite their old value,
    // so a store with no enables leaves the word unchanged.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                r_mem[i_addr][b*8 +: 8] <= be_merge(r_mem[i_addr][b*8 +: 8],
                                                    i_wdata[b*8 +: 8], i_be[b]);
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor data port. Accepts one request
// over a valid/ready handshake, spends WAIT_CYCLES wait states, commits the
// access on the edge that enters the response state, then holds the
// response until the requester takes it. One transaction in flight.
// Optional feature macro: DATA_MEM_RESPONDER_ERR_EN adds the rsp_err port
// and flags addresses outside the RAM (store suppressed, rdata 0).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_addr             byte address (bits [1:0] ignored)
//   req_wdata, req_be    store data and byte enables
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            load data, 0 for stores
//   rsp_err              out-of-range flag (only with the macro)
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata
`ifdef DATA_MEM_RESPONDER_ERR_EN
    ,
    output logic                    rsp_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int BE_W  = DATA_WIDTH/8;
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_t                r_state, w_next_state;
    logic [WAIT_CNT_W-1:0] r_cnt, w_next_cnt;
    logic                  w_accept, w_commit;

    logic                  r_we, r_oor;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_req_oor;
    logic                  w_c_we, w_c_oor;
    logic [IDX_W-1:0]      w_c_idx;
    logic [DATA_WIDTH-1:0] w_c_wdata;
    logic [BE_W-1:0]       w_c_be;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic                  w_unused_bits;

`ifdef DATA_MEM_RESPONDER_ERR_EN
    logic                  r_err;
    assign w_req_oor     = |req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign w_unused_bits = ^req_addr[1:0];
    assign rsp_err       = r_err;
`else
    // Upper address bits are dropped, so accesses alias modulo the depth.
    assign w_req_oor     = 1'b0;
    assign w_unused_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};
`endif

    // Next-state logic. The commit strobe marks the edge that enters RESP;
    // with zero wait states that is the accept edge itself.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = ST_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;

    // The committing transaction comes straight from the request port when
    // the commit happens on the accept edge, otherwise from the latches.
    assign w_c_we    = (r_state == ST_IDLE) ? req_we                  : r_we;
    assign w_c_oor   = (r_state == ST_IDLE) ? w_req_oor               : r_oor;
    assign w_c_idx   = (r_state == ST_IDLE) ? req_addr[IDX_W+1:2]     : r_idx;
    assign w_c_wdata = (r_state == ST_IDLE) ? req_wdata               : r_wdata;
    assign w_c_be    = (r_state == ST_IDLE) ? req_be                  : r_be;
    assign w_ram_we  = w_commit && w_c_we && !w_c_oor;

    dmem_ram_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_c_idx),
        .i_wdata (w_c_wdata),
        .i_be    (w_c_be),
        .o_rdata (w_ram_rdata)
    );

    // State, counter, request latches and response registers. Response
    // data only changes on a commit, so it holds while the requester stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
`ifdef DATA_MEM_RESPONDER_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_we    <= req_we;
                r_oor   <= w_req_oor;
                r_idx   <= req_addr[IDX_W+1:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_commit) begin
                r_rdata <= (w_c_we || w_c_oor) ? '0 : w_ram_rdata;
`ifdef DATA_MEM_RESPONDER_ERR_EN
                r_err   <= w_c_oor;
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Two instances share clock and
// reset: index 0 uses two wait states, index 1 uses none. Expected data
// comes from a word-array model of the RAM; latency from WAIT_CYCLES+1.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
`ifdef DATA_MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] ALIAS_EXP = ERR_EN ? 32'hCAFE0000 : 32'h00000001;

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        bit          poke;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  reqValid, reqReady, reqWe, rspValid, rspReady;
    logic [31:0] reqAddr  [2];
    logic [31:0] reqWdata [2];
    logic [31:0] rspRdata [2];
    logic [3:0]  reqBe    [2];
`ifdef DATA_MEM_RESPONDER_ERR_EN
    logic [1:0]  rspErr;
`endif

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;

    logic [31:0] modelMem   [2][DEPTH];
    bit          modelKnown [2][DEPTH];

    data_mem_responder #(.WAIT_CYCLES(2)) dutW2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0])
`ifdef DATA_MEM_RESPONDER_ERR_EN
        , .rsp_err(rspErr[0])
`endif
    );

    data_mem_responder #(.WAIT_CYCLES(0)) dutW0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1])
`ifdef DATA_MEM_RESPONDER_ERR_EN
        , .rsp_err(rspErr[1])
`endif
    );

    // Free-running clock and cycle counter used for throughput checks.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int wordOf(input logic [31:0] addr);
        return int'((addr / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic bit outOfRange(input logic [31:0] addr);
        return ERR_EN && (addr >= 32'(4 * DEPTH));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one transaction on instance d. Called and returns in the low
    // clock phase; checks latency, stall behaviour, data and the idle state
    // after the response handshake, then updates the RAM model.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int hold, input bit poke,
                                 output logic [31:0] rdata, output int acceptCyc,
                                 output int doneCyc);
        int          budget;
        int          lat;
        int          w;
        bit          expErr;
        bit          dataKnown;
        logic [31:0] expRdata;
        rdata     = '0;
        acceptCyc = 0;
        doneCyc   = 0;
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        reqBe[d]    = be;
        budget = 0;
        while (reqReady[d] !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (reqReady[d] !== 1'b1) begin
            checkOutput("accept_timeout", 32'(reqReady[d]), 32'd1);
            reqValid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        acceptCyc   = cycleCount;
        reqValid[d] = 1'b0;
        reqWe[d]    = 1'($urandom);
        reqAddr[d]  = $urandom;
        reqWdata[d] = $urandom;
        reqBe[d]    = 4'($urandom);
        lat = 1;
        while (rspValid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("latency_d%0d", d), 32'(lat), 32'(waitOf(d) + 1));

        w         = wordOf(addr);
        expErr    = outOfRange(addr);
        expRdata  = (!we && !expErr) ? modelMem[d][w] : 32'h0;
        dataKnown = we || expErr || modelKnown[d][w];
        rdata     = rspRdata[d];
        if (dataKnown) begin
            checkOutput($sformatf("rdata_d%0d_a%08h", d, addr), rdata, expRdata);
        end
`ifdef DATA_MEM_RESPONDER_ERR_EN
        checkOutput($sformatf("err_d%0d_a%08h", d, addr), 32'(rspErr[d]), 32'(expErr));
`endif
        checkOutput("req_ready_in_resp", 32'(reqReady[d]), 32'd0);

        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                reqValid[d] = 1'b1;
                reqWe[d]    = 1'b1;
                reqAddr[d]  = addr;
                reqWdata[d] = 32'h0BADF00D;
                reqBe[d]    = 4'hF;
            end
            @(negedge clk);
            checkOutput("stall_rsp_valid", 32'(rspValid[d]), 32'd1);
            checkOutput("stall_req_ready", 32'(reqReady[d]), 32'd0);
            if (dataKnown) begin
                checkOutput("stall_rdata", rspRdata[d], expRdata);
            end
        end
        rspReady[d] = 1'b1;
        @(negedge clk);
        rspReady[d] = 1'b0;
        reqValid[d] = 1'b0;
        doneCyc = cycleCount;
        checkOutput("post_rsp_valid", 32'(rspValid[d]), 32'd0);
        checkOutput("post_req_ready", 32'(reqReady[d]), 32'd1);

        if (we && !expErr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) modelMem[d][w][b*8 +: 8] = wdata[b*8 +: 8];
            end
            if (be == 4'hF) modelKnown[d][w] = 1'b1;
        end
    endtask

    vec_t        vecs[$];
    int          accs[$];
    int          dones[$];

    initial begin
        logic [31:0] rd;
        int          ac;
        int          dn;
        logic [31:0] addr;

        vecs.push_back('{0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h10,       32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{0, 1'b1, 32'h20,       32'h11223344, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b1, 32'h20,       32'h000000AA, 4'h1, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h20,       32'h0,        4'hF, 0, 1'b0, 32'h112233AA});
        vecs.push_back('{0, 1'b0, 32'h10,       32'h0,        4'h0, 5, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{0, 1'b0, 32'h13,       32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{0, 1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h22,       32'h0,        4'h0, 1, 1'b0, 32'h112233AA});
        vecs.push_back('{0, 1'b1, 32'h0,        32'hCAFE0000, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b1, 32'h00010000, 32'h00000001, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0,        32'h0,        4'h0, 0, 1'b0, ALIAS_EXP});
        vecs.push_back('{0, 1'b1, 32'h30,       32'h12345678, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b1, 32'h40,       32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h40,       32'h0,        4'h0, 0, 1'b0, 32'hA5A5A5A5});

        rst_n    = 1'b0;
        reqValid = '0;
        reqWe    = '0;
        rspReady = '0;
        for (int d = 0; d < 2; d++) begin
            reqAddr[d]  = '0;
            reqWdata[d] = '0;
            reqBe[d]    = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset_req_ready_d%0d", d), 32'(reqReady[d]), 32'd1);
            checkOutput($sformatf("reset_rsp_valid_d%0d", d), 32'(rspValid[d]), 32'd0);
            checkOutput($sformatf("reset_rdata_d%0d", d), rspRdata[d], 32'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                          vecs[i].hold, vecs[i].poke, rd, ac, dn);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
            accs.push_back(ac);
            dones.push_back(dn);
        end
        checkOutput("throughput_w2", 32'(accs[1] - accs[0]), 32'd4);
        checkOutput("back_to_back_w0", 32'(dones[14] - accs[13]), 32'd3);

        // Reset in the middle of a store's wait states: the store is dropped.
        reqValid[0] = 1'b1;
        reqWe[0]    = 1'b1;
        reqAddr[0]  = 32'h30;
        reqWdata[0] = 32'h00000055;
        reqBe[0]    = 4'hF;
        @(negedge clk);
        reqValid[0] = 1'b0;
        checkOutput("mid_store_in_wait", 32'(reqReady[0]), 32'd0);
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        #1;
        checkOutput("post_reset_rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("post_reset_req_ready", 32'(reqReady[0]), 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, rd, ac, dn);
        checkOutput("dropped_store", rd, 32'h12345678);

        // Seed a window of words on both instances, then random traffic.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                applyStimulus(d, 1'b1, 32'((64 + k) * 4), $urandom, 4'hF, 0, 1'b0, rd, ac, dn);
            end
        end
        for (int n = 0; n < 80; n++) begin
            addr = 32'((64 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                addr = addr | (32'($urandom_range(1, 255)) << 16);
            end
            applyStimulus(int'($urandom_range(0, 1)), 1'($urandom), addr, $urandom,
                          4'($urandom), int'($urandom_range(0, 2)),
                          $urandom_range(0, 3) == 0, rd, ac, dn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
